dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory. It shares the memory between the CPU load/store path (port 0) and the testbench loader/dump port (port 1). Requests are registered and granted round-robin, and the block drives the memory's read_address/write_address/write_enable/data_in. Read data returns one cycle after the access cycle, tagged to the granted port.

---
 rtl/dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the single-port data
// memory. Port 0 is the CPU load/store path, port 1 the loader/dump port.
// One access occupies one ACCESS cycle; the response (rdata/err) is registered
// at the edge ending that cycle and presented with a one-cycle rvalid pulse.
//
// Handshake: a requester holds pX_req high with we/addr/wdata stable until it
// sees pX_gnt. At the edge ending its gnt cycle it either drops req or already
// presents the next request. The owner's req is not sampled at that edge, so
// one port alone gets at most one access every two cycles. Both ports
// alternating sustain one access per cycle.
//
// Optional feature macro: DMEM_ARB_STATS_EN adds saturating 16-bit counters
// stat_gnt0, stat_gnt1 and stat_conflict as extra outputs.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = ACCESS) for checkers.

module dmem_arbiter #(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int unsigned ADDR_MAX = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   // port 0
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   // port 1
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   // memory side
   output logic [ADDR_W-1:0] mem_read_address,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic              mem_write_enable,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   // debug
   output logic              dbg_state
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_gnt0,
   output logic [15:0]       stat_gnt1,
   output logic [15:0]       stat_conflict
`endif
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(ADDR_MAX);

   // FSM and arbitration state
   state_t            state_q, state_d;
   logic              own_q, own_d;     // port owning the current ACCESS cycle
   logic              last_q, last_d;   // last granted port, loses the next tie
   logic              acc_we_q, acc_we_d;
   logic              acc_err_q, acc_err_d;

   // registered memory-side outputs
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;

   // registered requester-side outputs
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              err0_q, err0_d, err1_q, err1_d;

   // arbitration helpers
   logic              elig0, elig1, both_elig, win_valid, win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_err;
   logic [DATA_W-1:0] resp_data;

   // Eligibility and round-robin winner; the owner of an ACCESS cycle is masked
   always_comb begin
      elig0     = p0_req && !(state_q == ACCESS && own_q == 1'b0);
      elig1     = p1_req && !(state_q == ACCESS && own_q == 1'b1);
      both_elig = elig0 && elig1;
      win_valid = elig0 || elig1;
      win       = both_elig ? ~last_q : elig1;
      sel_we    = win ? p1_we    : p0_we;
      sel_addr  = win ? p1_addr  : p0_addr;
      sel_wdata = win ? p1_wdata : p0_wdata;
      sel_err   = sel_addr > ADDR_LIM;
      resp_data = (acc_we_q || acc_err_q) ? '0 : mem_data_out;
   end

   // Next-state: capture the winner into the access registers, and register the
   // response of the access that is ending at this edge
   always_comb begin
      state_d   = state_q;
      own_d     = own_q;
      last_d    = last_q;
      acc_we_d  = acc_we_q;
      acc_err_d = acc_err_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      err0_d     = 1'b0;
      err1_d     = 1'b0;

      if (win_valid) begin
         state_d    = ACCESS;
         own_d      = win;
         last_d     = win;
         acc_we_d   = sel_we;
         acc_err_d  = sel_err;
         mem_addr_d = sel_addr;
         mem_din_d  = sel_wdata;
         mem_we_d   = sel_we && !sel_err;
         gnt0_d     = ~win;
         gnt1_d     = win;
      end else begin
         state_d = IDLE;
      end

      if (state_q == ACCESS) begin
         if (own_q == 1'b0) begin
            rvalid0_d = 1'b1;
            rdata0_d  = resp_data;
            err0_d    = acc_err_q;
         end else begin
            rvalid1_d = 1'b1;
            rdata1_d  = resp_data;
            err1_d    = acc_err_q;
         end
      end
   end

   // FSM and output registers; reset drops write_enable without a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         own_q      <= 1'b0;
         last_q     <= 1'b1;
         acc_we_q   <= 1'b0;
         acc_err_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         own_q      <= own_d;
         last_q     <= last_d;
         acc_we_q   <= acc_we_d;
         acc_err_q  <= acc_err_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         err0_q     <= err0_d;
         err1_q     <= err1_d;
      end
   end

   assign p0_gnt            = gnt0_q;
   assign p1_gnt            = gnt1_q;
   assign p0_rvalid         = rvalid0_q;
   assign p1_rvalid         = rvalid1_q;
   assign p0_rdata          = rdata0_q;
   assign p1_rdata          = rdata1_q;
   assign p0_err            = err0_q;
   assign p1_err            = err1_q;
   assign mem_read_address  = mem_addr_q;
   assign mem_write_address = mem_addr_q;
   assign mem_write_enable  = mem_we_q;
   assign mem_data_in       = mem_din_q;
   assign dbg_state         = state_q;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] st_gnt0_q, st_gnt0_d;
   logic [15:0] st_gnt1_q, st_gnt1_d;
   logic [15:0] st_conf_q, st_conf_d;

   // Saturating usage counters: per-port ACCESS cycles and contended edges
   always_comb begin
      st_gnt0_d = st_gnt0_q;
      st_gnt1_d = st_gnt1_q;
      st_conf_d = st_conf_q;
      if (state_q == ACCESS && own_q == 1'b0 && st_gnt0_q != 16'hFFFF)
         st_gnt0_d = st_gnt0_q + 16'd1;
      if (state_q == ACCESS && own_q == 1'b1 && st_gnt1_q != 16'hFFFF)
         st_gnt1_d = st_gnt1_q + 16'd1;
      if (both_elig && st_conf_q != 16'hFFFF)
         st_conf_d = st_conf_q + 16'd1;
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_gnt0_q <= '0;
         st_gnt1_q <= '0;
         st_conf_q <= '0;
      end else begin
         st_gnt0_q <= st_gnt0_d;
         st_gnt1_q <= st_gnt1_d;
         st_conf_q <= st_conf_d;
      end
   end

   assign stat_gnt0     = st_gnt0_q;
   assign stat_gnt1     = st_gnt1_q;
   assign stat_conflict = st_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level model of the arbitration
// rules and a reference memory image.

module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        p0_gnt, p0_rvalid, p0_err;
   logic        p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_read_address, mem_write_address, mem_data_in, mem_data_out;
   logic        mem_write_enable;
   logic        dbg_state;

   // driven request fields, indexed by port
   logic        req_r [2];
   logic        we_r [2];
   logic [31:0] addr_r [2];
   logic [31:0] wdata_r [2];

   // memory attached to the DUT (environment) and reference image (model)
   logic [31:0] mem [256];
   logic [31:0] model_mem [256];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (actual running, required done)");
      $fatal(1);
   end

   dmem_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .p0_req            (req_r[0]),
      .p0_we             (we_r[0]),
      .p0_addr           (addr_r[0]),
      .p0_wdata          (wdata_r[0]),
      .p0_gnt            (p0_gnt),
      .p0_rvalid         (p0_rvalid),
      .p0_rdata          (p0_rdata),
      .p0_err            (p0_err),
      .p1_req            (req_r[1]),
      .p1_we             (we_r[1]),
      .p1_addr           (addr_r[1]),
      .p1_wdata          (wdata_r[1]),
      .p1_gnt            (p1_gnt),
      .p1_rvalid         (p1_rvalid),
      .p1_rdata          (p1_rdata),
      .p1_err            (p1_err),
      .mem_read_address  (mem_read_address),
      .mem_write_address (mem_write_address),
      .mem_write_enable  (mem_write_enable),
      .mem_data_in       (mem_data_in),
      .mem_data_out      (mem_data_out),
      .dbg_state         (dbg_state)
   );

   // single-port memory: combinational read, write at rising edge
   assign mem_data_out = mem[mem_read_address[7:0]];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
      mem[1] <= 32'd25;
      forever begin
         @(posedge clk);
         if (mem_write_enable) mem[mem_write_address[7:0]] <= mem_data_in;
      end
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   logic [64:0] pend0[$];
   logic [64:0] pend1[$];
   int gap_pct = 0;
   int cyc = 0;

   // model: which port owns the upcoming cycle, last winner, its access
   int          m_own;
   int          m_last;
   logic        m_we, m_err;
   logic [31:0] m_addr, m_wdata;
   // expectations for the next sampling point
   logic e_gnt0, e_gnt1, e_acc, e_we, e_rv0, e_rv1;

   // observation records
   int          we_cnt;
   logic [31:0] last_we_addr;
   logic [31:0] last_rdata0, last_rdata1;
   logic        last_err0;
   int          resp_cnt0;
   int          gnt_port[$];
   int          gnt_cyc[$];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_own  = -1;
      m_last = 1;
      m_we = 0; m_err = 0; m_addr = 0; m_wdata = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_acc = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0;
      exp_q0.delete();
      exp_q1.delete();
   endfunction

   function automatic logic [64:0] txn(input logic we, input logic [31:0] a, input logic [31:0] d);
      return {we, a, d};
   endfunction

   function automatic logic [64:0] rand_txn();
      int r;
      logic [31:0] a;
      r = $urandom_range(99);
      if (r < 8)       a = 32'd65536 + $urandom_range(3);
      else if (r < 12) a = 32'd65535;
      else             a = $urandom_range(15);
      return txn(1'($urandom_range(1)), a, $urandom);
   endfunction

   // ---------------- driver ----------------
   // A waiting requester holds; in its gnt cycle it drops or presents the next one
   task automatic drive_port(input int x);
      logic        g;
      logic        have;
      logic [64:0] t;
      g    = (x == 0) ? p0_gnt : p1_gnt;
      have = (x == 0) ? (pend0.size() > 0) : (pend1.size() > 0);
      if (req_r[x] && !g) return;
      req_r[x] = 1'b0;
      if (have && $urandom_range(99) >= gap_pct) begin
         if (x == 0) t = pend0.pop_front();
         else        t = pend1.pop_front();
         req_r[x]   = 1'b1;
         we_r[x]    = t[64];
         addr_r[x]  = t[63:32];
         wdata_r[x] = t[31:0];
      end
   endtask

   // ---------------- reference model ----------------
   // Applies what the coming rising edge does: commit the ending write, then pick
   // the next owner among eligible requesters (the current owner is not eligible)
   task automatic model_edge();
      logic el0, el1;
      int   w;
      if (m_own >= 0 && m_we && !m_err) model_mem[m_addr[7:0]] = m_wdata;
      e_rv0 = (m_own == 0);
      e_rv1 = (m_own == 1);
      el0 = req_r[0] && (m_own != 0);
      el1 = req_r[1] && (m_own != 1);
      if (el0 && el1)  w = (m_last == 0) ? 1 : 0;
      else if (el0)    w = 0;
      else if (el1)    w = 1;
      else             w = -1;
      if (w >= 0) begin
         m_we    = we_r[w];
         m_addr  = addr_r[w];
         m_wdata = wdata_r[w];
         m_err   = m_addr > 32'd65535;
         if (w == 0) exp_q0.push_back({m_err, (m_we || m_err) ? 32'd0 : model_mem[m_addr[7:0]]});
         else        exp_q1.push_back({m_err, (m_we || m_err) ? 32'd0 : model_mem[m_addr[7:0]]});
         m_last = w;
      end
      m_own  = w;
      e_acc  = (w >= 0);
      e_gnt0 = (w == 0);
      e_gnt1 = (w == 1);
      e_we   = (w >= 0) && m_we && !m_err;
   endtask

   // One cycle: sample at falling edge, compare, drive, advance the model
   task automatic step();
      logic [32:0] e;
      @(negedge clk);
      cyc++;
      check_eq("p0_gnt", p0_gnt, e_gnt0);
      check_eq("p1_gnt", p1_gnt, e_gnt1);
      check_eq("dbg_state", dbg_state, e_acc);
      check_eq("mem_write_enable", mem_write_enable, e_we);
      if (e_acc) begin
         check_eq("mem_write_address", mem_write_address, m_addr);
         check_eq("mem_read_address", mem_read_address, m_addr);
         check_eq("mem_data_in", mem_data_in, m_wdata);
      end
      check_eq("p0_rvalid", p0_rvalid, e_rv0);
      if (e_rv0) begin
         if (exp_q0.size() == 0) check_eq("p0_exp_present", 0, 1);
         else begin
            e = exp_q0.pop_front();
            check_eq("p0_rdata", p0_rdata, e[31:0]);
            check_eq("p0_err", p0_err, e[32]);
         end
      end
      check_eq("p1_rvalid", p1_rvalid, e_rv1);
      if (e_rv1) begin
         if (exp_q1.size() == 0) check_eq("p1_exp_present", 0, 1);
         else begin
            e = exp_q1.pop_front();
            check_eq("p1_rdata", p1_rdata, e[31:0]);
            check_eq("p1_err", p1_err, e[32]);
         end
      end
      if (mem_write_enable) begin we_cnt++; last_we_addr = mem_write_address; end
      if (p0_rvalid) begin resp_cnt0++; last_rdata0 = p0_rdata; last_err0 = p0_err; end
      if (p1_rvalid) last_rdata1 = p1_rdata;
      if (p0_gnt) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
      if (p1_gnt) begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
      drive_port(0);
      drive_port(1);
      model_edge();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pend0.size() > 0 || pend1.size() > 0 || req_r[0] || req_r[1] || e_acc ||
              e_rv0 || e_rv1 || exp_q0.size() > 0 || exp_q1.size() > 0) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) check_eq("drain_timeout", 1, 0);
      step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) req_r[i] = 1'b0;
      pend0.delete();
      pend1.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        ok;
      logic [31:0] saved, saved_model;
      int          n;

      for (int i = 0; i < 2; i++) begin
         req_r[i] = 1'b0; we_r[i] = 1'b0; addr_r[i] = '0; wdata_r[i] = '0;
      end
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h1000 + i;
      model_mem[1] = 32'd25;
      we_cnt = 0; last_we_addr = 0; last_rdata0 = 0; last_rdata1 = 0;
      last_err0 = 0; resp_cnt0 = 0;
      model_reset();

      // reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_gnt", {p0_gnt, p1_gnt}, 0);
      check_eq("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      check_eq("rst_err", {p0_err, p1_err}, 0);
      check_eq("rst_we", mem_write_enable, 0);
      check_eq("rst_rdata", {p0_rdata, p1_rdata}, 0);
      check_eq("rst_addr", {mem_read_address, mem_write_address}, 0);
      check_eq("rst_din", mem_data_in, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: p0 read of preloaded word
      pend0.push_back(txn(1'b0, 32'd1, 32'd0));
      drain();
      check_eq("t1_rdata", last_rdata0, 32'd25);
      check_eq("t1_err", last_err0, 0);

      // T2: p1 write then p0 read of the same word
      we_cnt = 0;
      pend1.push_back(txn(1'b1, 32'd2, 32'd14));
      drain();
      check_eq("t2_rdata1_zero", last_rdata1, 0);
      pend0.push_back(txn(1'b0, 32'd2, 32'd0));
      drain();
      check_eq("t2_we_cycles", we_cnt, 1);
      check_eq("t2_we_addr", last_we_addr, 32'd2);
      check_eq("t2_rdata", last_rdata0, 32'd14);

      // T3: both ports continuously requesting reads, right after reset
      do_reset();
      gnt_port.delete(); gnt_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         pend0.push_back(txn(1'b0, 32'd3 + i, 32'd0));
         pend1.push_back(txn(1'b0, 32'd8 + i, 32'd0));
      end
      drain();
      ok = (gnt_port.size() == 8);
      for (int i = 1; i < gnt_port.size(); i++) begin
         if (gnt_port[i] == gnt_port[i-1]) ok = 1'b0;
         if (gnt_cyc[i] != gnt_cyc[i-1] + 1) ok = 1'b0;
      end
      check_eq("t3_alternate_back_to_back", ok, 1);
      if (gnt_port.size() > 0) check_eq("t3_first_port", gnt_port[0], 0);
      else                     check_eq("t3_first_present", 0, 1);

      // T4: out-of-range write
      we_cnt = 0;
      saved = mem[255];
      pend0.push_back(txn(1'b1, 32'd65536, 32'd7));
      drain();
      check_eq("t4_we_cycles", we_cnt, 0);
      check_eq("t4_err", last_err0, 1);
      check_eq("t4_rdata", last_rdata0, 0);
      check_eq("t4_mem_top", mem[255], saved);

      // T5: p0 alone, new request presented in each gnt cycle
      gnt_cyc.delete(); gnt_port.delete();
      resp_cnt0 = 0;
      for (int i = 0; i < 3; i++) pend0.push_back(txn(1'b0, 32'd4 + i, 32'd0));
      drain();
      check_eq("t5_grants", gnt_cyc.size(), 3);
      check_eq("t5_responses", resp_cnt0, 3);
      ok = (gnt_cyc.size() == 3);
      for (int i = 1; i < gnt_cyc.size(); i++)
         if (gnt_cyc[i] != gnt_cyc[i-1] + 2) ok = 1'b0;
      check_eq("t5_every_other_cycle", ok, 1);

      // T6: reset asserted during a p1 write access
      saved       = mem[10];
      saved_model = model_mem[10];
      pend1.push_back(txn(1'b1, 32'd10, 32'd99));
      n = 0;
      do begin step(); n++; end while (!p1_gnt && n < 20);
      check_eq("t6_gnt_seen", p1_gnt, 1);
      check_eq("t6_we_before", mem_write_enable, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t6_we_async_drop", mem_write_enable, 0);
      check_eq("t6_gnt_drop", p1_gnt, 0);
      for (int i = 0; i < 2; i++) req_r[i] = 1'b0;
      pend0.delete(); pend1.delete();
      repeat (2) begin
         @(negedge clk);
         check_eq("t6_no_rvalid", p1_rvalid, 0);
      end
      check_eq("t6_mem_unchanged", mem[10], saved);
      model_mem[10] = saved_model;
      rst_n = 1'b1;
      model_reset();
      gnt_port.delete(); gnt_cyc.delete();
      pend0.push_back(txn(1'b0, 32'd5, 32'd0));
      pend1.push_back(txn(1'b0, 32'd6, 32'd0));
      drain();
      if (gnt_port.size() > 0) check_eq("t6_post_reset_tie", gnt_port[0], 0);
      else                     check_eq("t6_post_reset_present", 0, 1);

      // Randomized traffic
      gap_pct = 35;
      for (int i = 0; i < 800; i++) begin
         if (pend0.size() < 2 && $urandom_range(99) < 45) pend0.push_back(rand_txn());
         if (pend1.size() < 2 && $urandom_range(99) < 45) pend1.push_back(rand_txn());
         step();
      end
      gap_pct = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
